// File: rtl/fifo9_word_packer_pkg.sv
// Shared constants and payload types for the 9-bit FIFO wrappers and the word packer.
package fifo9_word_packer_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned EOF_BIT    = 8;
    localparam int unsigned FIFO_W     = 9;
    localparam int unsigned WORD_W     = BYTE_W * LANES;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned BE_CNT_W   = 3;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  be;
        logic              last;
    } word_t;

    // Number of enabled byte lanes in a word.
    function automatic logic [BE_CNT_W-1:0] be_count(input logic [LANES-1:0] be);
        logic [BE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + BE_CNT_W'(be[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo9_word_packer.sv
// Packs 9-bit FIFO entries (byte + end-of-frame flag) into 32-bit little-endian words
// with byte enables, a one-entry skid for the in-flight read, and frame length reporting.
module fifo9_word_packer
    import fifo9_word_packer_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FIFO_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [WORD_W-1:0] out_data,
    output logic [LANES-1:0]  out_be,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN_W-1:0]  frame_len,
    output logic              frame_done
);

    logic                  active;
    logic                  inflight;
    word_t                 acc;
    word_t                 acc_n;
    word_t                 out_w;
    logic [LANE_IDX_W-1:0] lane_idx;
    logic [LANE_IDX_W-1:0] lane_n;
    logic                  acc_done;
    logic                  done_n;
    logic                  skid_valid;
    logic                  skid_valid_n;
    logic [FIFO_W-1:0]     skid_q;
    logic [FIFO_W-1:0]     skid_q_n;
    logic [FIFO_W-1:0]     load_q;
    logic                  load_valid;
    logic                  move_c;
    logic                  handshake_c;
    logic [LEN_W:0]        cnt_sum;
    logic [LEN_W-1:0]      cnt_sat;
    logic [LEN_W-1:0]      frame_cnt;

    // 'active' keeps the read strobe low while and right after reset is asserted.
    assign fifo_rd_en  = active && !fifo_empty && !acc_done && !skid_valid;
    assign move_c      = acc_done && (!out_valid || out_ready);
    assign handshake_c = out_valid && out_ready;

    assign out_data = out_w.data;
    assign out_be   = out_w.be;
    assign out_last = out_w.last;

    // Accumulator next state: a move empties it, then the skid byte (or the byte
    // arriving that cycle) lands in lane 0 of the fresh word.
    always_comb begin
        acc_n        = acc;
        lane_n       = lane_idx;
        done_n       = acc_done;
        skid_valid_n = skid_valid;
        skid_q_n     = skid_q;
        load_valid   = 1'b0;
        load_q       = fifo_q;

        if (move_c) begin
            acc_n  = '0;
            lane_n = '0;
            done_n = 1'b0;
            if (skid_valid) begin
                load_valid   = 1'b1;
                load_q       = skid_q;
                skid_valid_n = 1'b0;
            end else if (inflight) begin
                load_valid = 1'b1;
            end
        end else if (inflight) begin
            if (acc_done) begin
                skid_valid_n = 1'b1;
                skid_q_n     = fifo_q;
            end else begin
                load_valid = 1'b1;
            end
        end

        if (load_valid) begin
            acc_n.data     = acc_n.data | (WORD_W'(load_q[BYTE_W-1:0]) << {lane_n, 3'b000});
            acc_n.be[lane_n] = 1'b1;
            acc_n.last     = load_q[EOF_BIT];
            done_n         = load_q[EOF_BIT] || (lane_n == LANE_IDX_W'(LANES - 1));
            lane_n         = lane_n + LANE_IDX_W'(1);
        end
    end

    // Saturating byte count including the word being handed off.
    always_comb begin
        cnt_sum = {1'b0, frame_cnt} + (LEN_W + 1)'(be_count(out_w.be));
        cnt_sat = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            inflight   <= 1'b0;
            acc        <= '0;
            lane_idx   <= '0;
            acc_done   <= 1'b0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else begin
            active     <= 1'b1;
            inflight   <= fifo_rd_en;
            acc        <= acc_n;
            lane_idx   <= lane_n;
            acc_done   <= done_n;
            skid_valid <= skid_valid_n;
            skid_q     <= skid_q_n;
        end
    end

    // Output register holds its word until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_w     <= '0;
            out_valid <= 1'b0;
        end else if (move_c) begin
            out_w     <= acc;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (handshake_c) begin
                if (out_w.last) begin
                    frame_len  <= cnt_sat;
                    frame_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= cnt_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo9_word_packer.sv
// Scoreboard bench for fifo9_word_packer: byte frames go into a FIFO model, expected
// words and frame lengths are queued from a chunking model and checked by a monitor.
module tb_fifo9_word_packer;
    import fifo9_word_packer_pkg::*;

    localparam int unsigned LEN_W = 10;
    localparam int unsigned SAT   = (1 << LEN_W) - 1;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic [FIFO_W-1:0] fifo_q     = '0;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] out_data;
    logic [LANES-1:0]  out_be;
    logic              out_last;
    logic              out_valid;
    logic              out_ready  = 1'b0;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_done;

    fifo9_word_packer #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_be     (out_be),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_len  (frame_len),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [FIFO_W-1:0] src_q[$];
    word_t             exp_w_q[$];
    int unsigned       exp_len_q[$];
    int                n_checks   = 0;
    int                n_fail     = 0;
    int                ready_mode = 0;
    int                gap_en     = 0;
    int unsigned       cyc        = 0;
    logic              held_v     = 1'b0;
    word_t             held_w;
    word_t             mon_e;
    int unsigned       mon_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: split the frame into 4-byte chunks, last chunk carries the flag.
    task automatic send_frame(input logic [7:0] bytes[$]);
        int unsigned n;
        word_t       w;
        n = bytes.size();
        for (int unsigned k = 0; k < n; k += 4) begin
            w = '0;
            for (int unsigned j = 0; j < 4 && k + j < n; j++) begin
                w.data[8*j +: 8] = bytes[k+j];
                w.be[j]          = 1'b1;
            end
            w.last = (k + 4 >= n);
            exp_w_q.push_back(w);
        end
        exp_len_q.push_back(n > SAT ? SAT : n);
        for (int unsigned i = 0; i < n; i++) src_q.push_back({i == n - 1, bytes[i]});
    endtask

    // FIFO model: one-cycle read latency, optional random empty gaps.
    always @(posedge clk) begin
        if (rst_n && fifo_rd_en && !fifo_empty) fifo_q <= src_q.pop_front();
    end

    always @(negedge clk) begin
        fifo_empty <= (src_q.size() == 0) || (gap_en != 0 && $urandom_range(0, 3) == 0);
    end

    // Monitor: choose out_ready for the coming edge, then check what that edge will accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (held_v) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_word", 64'({out_data, out_be, out_last}), 64'(held_w));
            end
            if (out_valid && out_ready) begin
                if (exp_w_q.size() == 0) begin
                    fail_now("extra_word");
                end else begin
                    mon_e = exp_w_q.pop_front();
                    check("word{data,be,last}", 64'({out_data, out_be, out_last}), 64'(mon_e));
                end
            end
            if (frame_done) begin
                if (exp_len_q.size() == 0) begin
                    fail_now("extra_frame_done");
                end else begin
                    mon_len = exp_len_q.pop_front();
                    check("frame_len", 64'(frame_len), 64'(mon_len));
                end
            end
            if (dut.skid_valid) check("rd_stall_on_skid", 64'(fifo_rd_en), 64'(0));
            held_v = out_valid && !out_ready;
            held_w = {out_data, out_be, out_last};
        end
    end

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((src_q.size() != 0 || exp_w_q.size() != 0 || exp_len_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (src_q.size() != 0 || exp_w_q.size() != 0 || exp_len_q.size() != 0) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_out_be"}, 64'(out_be), 64'(0));
        check({tag, "_out_last"}, 64'(out_last), 64'(0));
        check({tag, "_frame_len"}, 64'(frame_len), 64'(0));
        check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        check({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'(0));
    endtask

    initial begin
        logic [7:0] bytes[$];
        int unsigned nb;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // 8 bytes, two full words
        ready_mode = 0;
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(bytes);
        drain(200);

        // 5 bytes, short trailing word
        bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_frame(bytes);
        drain(200);

        // 64 bytes with consumer ready one cycle in four
        ready_mode = 1;
        bytes.delete();
        for (int i = 0; i < 64; i++) bytes.push_back(8'(i * 3 + 1));
        send_frame(bytes);
        drain(2000);

        // back-to-back one-byte frames
        ready_mode = 0;
        bytes = '{8'h11};
        send_frame(bytes);
        bytes = '{8'h22};
        send_frame(bytes);
        drain(200);

        // reset with a partial word accumulated
        src_q.push_back(9'h055);
        src_q.push_back(9'h066);
        repeat (10) @(negedge clk);
        check("partial_no_word", 64'(out_valid), 64'(0));
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bytes = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        send_frame(bytes);
        drain(200);

        // random frames, random backpressure and FIFO gaps
        ready_mode = 2;
        gap_en     = 1;
        for (int f = 0; f < 25; f++) begin
            bytes.delete();
            nb = $urandom_range(1, 13);
            for (int unsigned i = 0; i < nb; i++) bytes.push_back(8'($urandom));
            send_frame(bytes);
        end
        drain(5000);

        // frame longer than the length counter can represent
        ready_mode = 0;
        gap_en     = 0;
        bytes.delete();
        for (int i = 0; i < 1100; i++) bytes.push_back(8'(i));
        send_frame(bytes);
        drain(3000);

        check("leftover_words", 64'(exp_w_q.size()), 64'(0));
        check("leftover_lens", 64'(exp_len_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        fail_now("global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
